// File: rtl/m_stage_if.sv
// Bundles the execute-to-memory inputs, the write-back forwarding inputs and
// the memory/write-back pipeline outputs of the MIPS memory stage.
interface m_stage_if;
  // Execute-side inputs
  logic [31:0] E_PC;
  logic [31:0] E_instr;
  logic [31:0] E_ALUout;
  logic [31:0] E_F_D2;
  logic        E2M_clr;
  // Store-data forwarding from write-back
  logic        M_FMUX_slt;
  logic [31:0] W_wdata;
  // Pipeline register outputs
  logic [31:0] E2M_ALUout;
  logic [31:0] M_PC;
  logic [31:0] M_instr;
  logic [31:0] M2W_ALUout;
  logic [31:0] M2W_MEMout;
  logic [31:0] W_PC;
  logic [31:0] W_instr;

  // Upstream pipeline / testbench side
  modport master (
    output E_PC, E_instr, E_ALUout, E_F_D2, E2M_clr, M_FMUX_slt, W_wdata,
    input  E2M_ALUout, M_PC, M_instr, M2W_ALUout, M2W_MEMout, W_PC, W_instr
  );

  // Memory stage side
  modport slave (
    input  E_PC, E_instr, E_ALUout, E_F_D2, E2M_clr, M_FMUX_slt, W_wdata,
    output E2M_ALUout, M_PC, M_instr, M2W_ALUout, M2W_MEMout, W_PC, W_instr
  );
endinterface

// File: rtl/m_stage.sv
// Memory stage of the 5-stage MIPS pipeline: E/M register, word/half/byte
// loads and stores on an internal data memory, and the M/W register.
module m_stage #(
  parameter int unsigned DM_ADDR_W = 12,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000
) (
  input logic       clk,
  input logic       reset_n,
  m_stage_if.slave  bus
);

  localparam int unsigned Depth = 2 ** DM_ADDR_W;

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // E/M pipeline register
  logic [31:0] pc_em_q, pc_em_d;
  logic [31:0] instr_em_q, instr_em_d;
  logic [31:0] alu_em_q, alu_em_d;
  logic [31:0] rt_em_q, rt_em_d;

  // M/W pipeline register
  logic [31:0] pc_mw_q, pc_mw_d;
  logic [31:0] instr_mw_q, instr_mw_d;
  logic [31:0] alu_mw_q, alu_mw_d;
  logic [31:0] mem_mw_q, mem_mw_d;

  // Data memory and access datapath
  logic [31:0]          mem_q [Depth];
  logic [DM_ADDR_W-1:0] word_idx;
  logic [1:0]           byte_lane;
  logic [31:0]          rd_word;
  logic [31:0]          wr_word;
  logic [31:0]          st_data;
  logic [7:0]           byte_val;
  logic [15:0]          half_val;
  logic [5:0]           opcode;
  logic                 ld_en;
  logic                 st_en;
  logic                 ld_sign;
  size_e                acc_size;
  logic                 unused_addr_bits;

  // Flush clears the payload but keeps the PC flowing for the bubble
  always_comb begin
    pc_em_d    = bus.E_PC;
    instr_em_d = bus.E_instr;
    alu_em_d   = bus.E_ALUout;
    rt_em_d    = bus.E_F_D2;
    if (bus.E2M_clr) begin
      instr_em_d = '0;
      alu_em_d   = '0;
      rt_em_d    = '0;
    end
  end

  // E/M register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_em_q    <= PC_RESET;
      instr_em_q <= '0;
      alu_em_q   <= '0;
      rt_em_q    <= '0;
    end else begin
      pc_em_q    <= pc_em_d;
      instr_em_q <= instr_em_d;
      alu_em_q   <= alu_em_d;
      rt_em_q    <= rt_em_d;
    end
  end

  // Address split; upper address bits are dropped so accesses wrap
  assign opcode           = instr_em_q[31:26];
  assign word_idx         = alu_em_q[DM_ADDR_W+1:2];
  assign byte_lane        = alu_em_q[1:0];
  assign unused_addr_bits = ^alu_em_q[31:DM_ADDR_W+2];
  assign rd_word          = mem_q[word_idx];
  assign st_data          = bus.M_FMUX_slt ? bus.W_wdata : rt_em_q;

  // Opcode decode into access kind, width and signedness
  always_comb begin
    ld_en    = 1'b0;
    st_en    = 1'b0;
    ld_sign  = 1'b0;
    acc_size = SzWord;
    case (opcode)
      OpLw:  begin ld_en = 1'b1; acc_size = SzWord; end
      OpLh:  begin ld_en = 1'b1; acc_size = SzHalf; ld_sign = 1'b1; end
      OpLhu: begin ld_en = 1'b1; acc_size = SzHalf; end
      OpLb:  begin ld_en = 1'b1; acc_size = SzByte; ld_sign = 1'b1; end
      OpLbu: begin ld_en = 1'b1; acc_size = SzByte; end
      OpSw:  begin st_en = 1'b1; acc_size = SzWord; end
      OpSh:  begin st_en = 1'b1; acc_size = SzHalf; end
      OpSb:  begin st_en = 1'b1; acc_size = SzByte; end
      default: ;
    endcase
  end

  // Merge store data into the current word so unselected lanes survive
  always_comb begin
    wr_word = rd_word;
    unique case (acc_size)
      SzWord: wr_word = st_data;
      SzHalf: wr_word[{byte_lane[1], 4'b0000} +: 16] = st_data[15:0];
      SzByte: wr_word[{byte_lane, 3'b000} +: 8] = st_data[7:0];
      default: wr_word = rd_word;
    endcase
  end

  // Data memory: cleared by reset, written at the edge ending the M cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (st_en) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  // Lane select and extension of load data
  always_comb begin
    byte_val = rd_word[{byte_lane, 3'b000} +: 8];
    half_val = rd_word[{byte_lane[1], 4'b0000} +: 16];
    mem_mw_d = '0;
    if (ld_en) begin
      unique case (acc_size)
        SzWord: mem_mw_d = rd_word;
        SzHalf: mem_mw_d = {{16{ld_sign & half_val[15]}}, half_val};
        SzByte: mem_mw_d = {{24{ld_sign & byte_val[7]}}, byte_val};
        default: mem_mw_d = '0;
      endcase
    end
  end

  // M/W next state
  always_comb begin
    pc_mw_d    = pc_em_q;
    instr_mw_d = instr_em_q;
    alu_mw_d   = alu_em_q;
  end

  // M/W register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_mw_q    <= PC_RESET;
      instr_mw_q <= '0;
      alu_mw_q   <= '0;
      mem_mw_q   <= '0;
    end else begin
      pc_mw_q    <= pc_mw_d;
      instr_mw_q <= instr_mw_d;
      alu_mw_q   <= alu_mw_d;
      mem_mw_q   <= mem_mw_d;
    end
  end

  assign bus.E2M_ALUout = alu_em_q;
  assign bus.M_PC       = pc_em_q;
  assign bus.M_instr    = instr_em_q;
  assign bus.M2W_ALUout = alu_mw_q;
  assign bus.M2W_MEMout = mem_mw_q;
  assign bus.W_PC       = pc_mw_q;
  assign bus.W_instr    = instr_mw_q;

endmodule

// File: tb/tb_m_stage.sv
// Directed bench for the MIPS memory stage: reset, word and sub-word
// accesses, store-data forwarding, flush and address wrap.
module tb_m_stage;

  localparam logic [5:0] OpNop = 6'b000000;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [31:0] pc_r;

  m_stage_if bus ();

  m_stage #(
    .DM_ADDR_W (12),
    .PC_RESET  (32'h0000_3000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [5:0] op);
    if (op == OpNop) return 32'h0;
    return {op, 5'd1, 5'd2, 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction at the E inputs and advance one clock edge
  task automatic issue(input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic clr);
    pc_r          = pc_r + 32'd4;
    bus.E_PC      = pc_r;
    bus.E_instr   = mk_instr(op);
    bus.E_ALUout  = alu;
    bus.E_F_D2    = rt;
    bus.E2M_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    pc_r           = 32'h0000_0100;
    reset_n        = 1'b0;
    bus.E_PC       = '0;
    bus.E_instr    = '0;
    bus.E_ALUout   = '0;
    bus.E_F_D2     = '0;
    bus.E2M_clr    = 1'b0;
    bus.M_FMUX_slt = 1'b0;
    bus.W_wdata    = '0;

    // Power-on reset
    @(posedge clk);
    #1;
    chk("rst_m_pc", bus.M_PC, 32'h0000_3000);
    chk("rst_w_pc", bus.W_PC, 32'h0000_3000);
    chk("rst_m_instr", bus.M_instr, 32'h0);
    chk("rst_e2m_alu", bus.E2M_ALUout, 32'h0);
    chk("rst_m2w_mem", bus.M2W_MEMout, 32'h0);
    reset_n = 1'b1;

    // Mid-stream reset with a store pending in M
    issue(OpSw, 32'h0000_0000, 32'h0000_CAFE, 1'b0);
    issue(OpSw, 32'h0000_0040, 32'h0000_1234, 1'b0);
    chk("pre_rst_m_instr", bus.M_instr, mk_instr(OpSw));
    chk("pre_rst_w_pc", bus.W_PC, 32'h0000_0104);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_pc", bus.M_PC, 32'h0000_3000);
    chk("mid_rst_w_pc", bus.W_PC, 32'h0000_3000);
    chk("mid_rst_m_instr", bus.M_instr, 32'h0);
    chk("mid_rst_w_instr", bus.W_instr, 32'h0);
    chk("mid_rst_e2m_alu", bus.E2M_ALUout, 32'h0);
    chk("mid_rst_m2w_alu", bus.M2W_ALUout, 32'h0);
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b1;

    // Memory cleared by reset, pending store never committed
    issue(OpLw, 32'h0000_0000, 32'h0, 1'b0);
    issue(OpLw, 32'h0000_0040, 32'h0, 1'b0);
    chk("lw0_after_rst", bus.M2W_MEMout, 32'h0);
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    chk("lw40_after_rst", bus.M2W_MEMout, 32'h0);

    // Word round trip with 2-cycle latency
    issue(OpSw, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    issue(OpLw, 32'h0000_0010, 32'h0, 1'b0);
    chk("sw_memout_zero", bus.M2W_MEMout, 32'h0);
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    chk("lw_roundtrip", bus.M2W_MEMout, 32'hDEAD_BEEF);
    chk("lw_m2w_alu", bus.M2W_ALUout, 32'h0000_0010);
    chk("lw_w_instr", bus.W_instr, mk_instr(OpLw));

    // Sub-word stores and extending loads
    issue(OpSw, 32'h0000_0020, 32'h1122_3344, 1'b0);
    issue(OpSb, 32'h0000_0022, 32'h1234_56AA, 1'b0);
    issue(OpLw, 32'h0000_0020, 32'h0, 1'b0);
    issue(OpLb, 32'h0000_0022, 32'h0, 1'b0);
    chk("sb_word", bus.M2W_MEMout, 32'h11AA_3344);
    issue(OpLbu, 32'h0000_0022, 32'h0, 1'b0);
    chk("lb_sext", bus.M2W_MEMout, 32'hFFFF_FFAA);
    issue(OpSh, 32'h0000_0021, 32'hFFFF_8001, 1'b0);
    chk("lbu_zext", bus.M2W_MEMout, 32'h0000_00AA);
    issue(OpLw, 32'h0000_0020, 32'h0, 1'b0);
    chk("sh_memout_zero", bus.M2W_MEMout, 32'h0);
    issue(OpLh, 32'h0000_0020, 32'h0, 1'b0);
    chk("sh_word", bus.M2W_MEMout, 32'h11AA_8001);
    issue(OpLhu, 32'h0000_0020, 32'h0, 1'b0);
    chk("lh_sext", bus.M2W_MEMout, 32'hFFFF_8001);
    issue(OpLh, 32'h0000_0022, 32'h0, 1'b0);
    chk("lhu_zext", bus.M2W_MEMout, 32'h0000_8001);
    issue(OpLb, 32'h0000_0021, 32'h0, 1'b0);
    chk("lh_upper_pos", bus.M2W_MEMout, 32'h0000_11AA);
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    chk("lb_lane1", bus.M2W_MEMout, 32'hFFFF_FF80);

    // Store data forwarded from write-back
    issue(OpSw, 32'h0000_0050, 32'h0000_0005, 1'b0);
    bus.M_FMUX_slt = 1'b1;
    bus.W_wdata    = 32'h0000_0077;
    issue(OpLw, 32'h0000_0050, 32'h0, 1'b0);
    bus.M_FMUX_slt = 1'b0;
    bus.W_wdata    = 32'h0;
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    chk("fwd_store", bus.M2W_MEMout, 32'h0000_0077);

    // Flush drops the incoming store; the store already in M commits
    issue(OpSw, 32'h0000_0060, 32'h0000_ABCD, 1'b0);
    issue(OpSw, 32'h0000_0030, 32'h0000_0099, 1'b1);
    chk("flush_m_instr", bus.M_instr, 32'h0);
    chk("flush_e2m_alu", bus.E2M_ALUout, 32'h0);
    chk("flush_m_pc", bus.M_PC, pc_r);
    issue(OpLw, 32'h0000_0030, 32'h0, 1'b0);
    issue(OpLw, 32'h0000_0060, 32'h0, 1'b0);
    chk("flush_no_write", bus.M2W_MEMout, 32'h0);
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    chk("flush_prior_commit", bus.M2W_MEMout, 32'h0000_ABCD);

    // Address wraps modulo the memory depth
    issue(OpSw, 32'h0000_4010, 32'h5A5A_1234, 1'b0);
    issue(OpLw, 32'h0000_0010, 32'h0, 1'b0);
    issue(OpNop, 32'h0, 32'h0, 1'b0);
    chk("wrap", bus.M2W_MEMout, 32'h5A5A_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_stage.md
Name: m_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the E/M pipeline register, which captures ALUout, forwarded store data, PC and instr from execute.
- Performs loads and stores (word/half/byte, sign/zero extension) on an internal data memory.
- Holds the M/W pipeline register, which produces the M2W_ALUout / M2W_MEMout forwarding sources used by execute.

Parameters:
- DM_ADDR_W, 12, word-address width of data memory; depth = 2^DM_ADDR_W words.
- PC_RESET, 32'h0000_3000, reset value of both PC pipeline registers.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- E_PC  in  32  PC of the instruction leaving execute
- E_instr  in  32  instruction leaving execute
- E_ALUout  in  32  ALU result / effective address from execute
- E_F_D2  in  32  forwarded rt value from execute (store data)
- E2M_clr  in  1  synchronous flush of the E/M register (insert bubble)
- M_FMUX_slt  in  1  store-data forward select: 0 = registered rt, 1 = W_wdata
- W_wdata  in  32  register-file write-back value of the instruction in W
- E2M_ALUout  out  32  E/M-registered ALU result (forwarding source)
- M_PC  out  32  E/M-registered PC
- M_instr  out  32  E/M-registered instr
- M2W_ALUout  out  32  M/W-registered ALU result
- M2W_MEMout  out  32  M/W-registered extended load data
- W_PC  out  32  M/W-registered PC
- W_instr  out  32  M/W-registered instr

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately, including mid-operation):
  - M_PC and W_PC = PC_RESET.
  - All other registered outputs = 0; instr=0 is a nop.
  - Every data-memory word is cleared to 0.
  - No write occurs while reset is asserted.
- E/M register, each rising edge:
  - E2M_clr=1: ALUout, rt and instr load 0; PC loads E_PC.
  - Otherwise: loads E_PC, E_instr, E_ALUout, E_F_D2.
- Store data = M_FMUX_slt ? W_wdata : registered rt. Combinational; used only in M.
- Decode uses M_instr[31:26]:
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - Any other opcode: no memory access.
- Address:
  - Word index = E2M_ALUout[DM_ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo the depth.
  - Byte lane = E2M_ALUout[1:0]. Lanes are little-endian: lane 0 = bits 7:0.
- Stores (synchronous write at the rising edge ending the M cycle):
  - sw writes the full word; addr[1:0] ignored.
  - sh writes halfword lane addr[1] with data[15:0]; addr[0] ignored.
  - sb writes byte lane addr[1:0] with data[7:0].
  - Unselected lanes are unchanged.
- Loads (combinational read of the current word, extended per opcode):
  - lw: the whole word.
  - lh / lhu: the selected halfword, sign- / zero-extended.
  - lb / lbu: the selected byte, sign- / zero-extended.
  - Non-load instructions: MEMout = 0.
- M/W register, each rising edge: captures M_PC, M_instr, E2M_ALUout and the extended load value. Latency from E inputs to M2W_* is 2 cycles; the stage has no stall.
- Read-during-write to the same word in the same cycle:
  - Cannot occur within a single instruction.
  - A load in M always sees memory as written by all earlier stores, which committed at earlier edges.
- Flush on the same edge a store sits in M: that store still commits, because the flush clears only the incoming E/M contents.

Test Plan:
- Reset: assert reset_n=0 mid-stream with a pending sw in M -> M_PC=W_PC=32'h3000, other outputs 0. After release, lw from address 0 returns M2W_MEMout=0.
- Word round-trip: sw 32'hDEADBEEF to 0x10, then lw 0x10 -> M2W_MEMout=32'hDEADBEEF exactly 2 cycles after lw is presented at E inputs. M2W_ALUout=0x10.
- Sub-word:
  - Start from word 0x20 = 32'h11223344.
  - sb 8'hAA to 0x22 -> word = 32'h11AA3344.
  - lb 0x22 -> 32'hFFFFFFAA; lbu 0x22 -> 32'h000000AA.
  - sh 16'h8001 to 0x20 -> word = 32'h11AA8001.
  - lh 0x20 -> 32'hFFFF8001; lhu 0x20 -> 32'h00008001.
- Store-data forwarding: sw with stale rt=5, M_FMUX_slt=1, W_wdata=32'h77 -> memory word holds 32'h77, not 5.
- Flush: E2M_clr=1 while E presents sw to 0x30 -> next-cycle M_instr=0, memory at 0x30 unchanged. A store already in M at that edge still commits.
- Wrap-around with DM_ADDR_W=12: sw to 0x4010 -> lw 0x0010 returns the stored value.
